branch_predictor: RTL and testbench

Fetch-stage branch predictor and target buffer. It is the producer side of the branch decision that the decode-stage comparator resolves. Each fetch PC receives a taken/not-taken prediction and a predicted next PC. Decode-stage resolutions train the table and are checked against the original prediction, and a registered mispredict/redirect is raised when the two disagree.

---
 rtl/branch_predictor_if.sv | 38 +++
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle of the branch predictor: the fetch stage and decode stage
// drive the master side; the predictor is the slave.
interface branch_predictor_if #(
    parameter int CNT_WIDTH = 16
) ();
    logic [31:0]          fetch_pc;
    logic                 predict_hit;
    logic                 predict_taken;
    logic [31:0]          predict_next_pc;

    logic                 resolve_valid;
    logic [31:0]          resolve_pc;
    logic                 resolve_taken;
    logic [31:0]          resolve_target;
    logic                 resolve_pred_taken;
    logic [31:0]          resolve_pred_next_pc;

    logic                 mispredict;
    logic [31:0]          redirect_pc;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] mispredict_count;

    modport master (
        output fetch_pc,
        output resolve_valid, resolve_pc, resolve_taken, resolve_target,
        output resolve_pred_taken, resolve_pred_next_pc,
        input  predict_hit, predict_taken, predict_next_pc,
        input  mispredict, redirect_pc, branch_count, mispredict_count
    );

    modport slave (
        input  fetch_pc,
        input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
        input  resolve_pred_taken, resolve_pred_next_pc,
        output predict_hit, predict_taken, predict_next_pc,
        output mispredict, redirect_pc, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters, trained by decode-stage
// resolutions, with a registered mispredict/redirect pulse and saturating statistics.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    logic                 valid_q  [ENTRIES];
    logic                 valid_d  [ENTRIES];
    logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
    logic [TAG_BITS-1:0]  tag_d    [ENTRIES];
    logic [31:0]          target_q [ENTRIES];
    logic [31:0]          target_d [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];
    logic [1:0]           ctr_d    [ENTRIES];

    logic                 mispredict_q, mispredict_d;
    logic [31:0]          redirect_pc_q, redirect_pc_d;
    logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    logic [INDEX_BITS-1:0] fetch_idx, resolve_idx;
    logic [TAG_BITS-1:0]   fetch_tag, resolve_tag;
    logic                  fetch_hit, fetch_taken;
    logic                  resolve_hit, resolve_err;
    logic [31:0]           correct_next;

    assign fetch_idx   = bp.fetch_pc[INDEX_BITS+1:2];
    assign fetch_tag   = bp.fetch_pc[31:INDEX_BITS+2];
    assign resolve_idx = bp.resolve_pc[INDEX_BITS+1:2];
    assign resolve_tag = bp.resolve_pc[31:INDEX_BITS+2];

    // Prediction reads the registered table directly, so a same-cycle update is not visible.
    always_comb begin
        fetch_hit          = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        fetch_taken        = fetch_hit && ctr_q[fetch_idx][1];
        bp.predict_hit     = fetch_hit;
        bp.predict_taken   = fetch_taken;
        bp.predict_next_pc = fetch_taken ? target_q[fetch_idx] : bp.fetch_pc + 32'd4;
    end

    always_comb begin
        valid_d     = valid_q;
        tag_d       = tag_q;
        target_d    = target_q;
        ctr_d       = ctr_q;
        resolve_hit = valid_q[resolve_idx] && (tag_q[resolve_idx] == resolve_tag);
        if (bp.resolve_valid) begin
            if (resolve_hit) begin
                if (bp.resolve_taken) begin
                    if (ctr_q[resolve_idx] != 2'b11) begin
                        ctr_d[resolve_idx] = ctr_q[resolve_idx] + 2'd1;
                    end
                    target_d[resolve_idx] = bp.resolve_target;
                end else if (ctr_q[resolve_idx] != 2'b00) begin
                    ctr_d[resolve_idx] = ctr_q[resolve_idx] - 2'd1;
                end
            end else if (bp.resolve_taken) begin
                // A taken miss evicts whatever aliases at this index, starting weakly taken.
                valid_d[resolve_idx]  = 1'b1;
                tag_d[resolve_idx]    = resolve_tag;
                target_d[resolve_idx] = bp.resolve_target;
                ctr_d[resolve_idx]    = 2'b10;
            end
        end
    end

    always_comb begin
        correct_next = bp.resolve_taken ? bp.resolve_target : bp.resolve_pc + 32'd4;
        resolve_err  = bp.resolve_valid &&
                       ((correct_next != bp.resolve_pred_next_pc) ||
                        (bp.resolve_taken != bp.resolve_pred_taken));
        mispredict_d  = resolve_err;
        redirect_pc_d = resolve_err ? correct_next : redirect_pc_q;

        branch_count_d = branch_count_q;
        if (bp.resolve_valid && (branch_count_q != {CNT_WIDTH{1'b1}})) begin
            branch_count_d = branch_count_q + CNT_WIDTH'(1);
        end
        mispredict_count_d = mispredict_count_q;
        if (resolve_err && (mispredict_count_q != {CNT_WIDTH{1'b1}})) begin
            mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            mispredict_q       <= 1'b0;
            redirect_pc_q      <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            mispredict_q       <= mispredict_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bp.mispredict       = mispredict_q;
    assign bp.redirect_pc      = redirect_pc_q;
    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a scoreboard queue holds the expected
// mispredict/redirect/statistics for each cycle, popped one cycle after the resolution.
module tb_branch_predictor;
    localparam int CNT_WIDTH = 16;

    typedef struct packed {
        logic        mis;
        logic [31:0] redir;
        logic [15:0] branches;
        logic [15:0] mispredicts;
    } exp_t;

    logic clk;
    logic rst_n;
    branch_predictor_if #(.CNT_WIDTH(CNT_WIDTH)) bp_if ();

    branch_predictor #(.INDEX_BITS(6), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if)
    );

    exp_t        sb_q[$];
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    logic [31:0] exp_redirect;
    logic [15:0] exp_branches;
    logic [15:0] exp_mispredicts;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one resolution (or idle) and records what the DUT must show after the next edge.
    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic taken,
                                 input logic [31:0] target, input logic pred_taken,
                                 input logic [31:0] pred_next);
        logic [31:0] correct;
        logic        err;
        bp_if.resolve_valid        = valid;
        bp_if.resolve_pc           = pc;
        bp_if.resolve_taken        = taken;
        bp_if.resolve_target       = target;
        bp_if.resolve_pred_taken   = pred_taken;
        bp_if.resolve_pred_next_pc = pred_next;
        correct = taken ? target : pc + 32'd4;
        err     = valid && ((correct != pred_next) || (taken != pred_taken));
        if (valid && exp_branches != 16'hFFFF) exp_branches++;
        if (err && exp_mispredicts != 16'hFFFF) exp_mispredicts++;
        if (err) exp_redirect = correct;
        sb_q.push_back('{mis: err, redir: exp_redirect, branches: exp_branches,
                         mispredicts: exp_mispredicts});
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (sb_q.size() > 0) passes++;
        else begin
            fails++;
            $error("[TB] FAIL sb_underflow: observed %0d entries expected >0", sb_q.size());
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("mispredict", {31'b0, bp_if.mispredict}, {31'b0, e.mis});
            check("redirect_pc", bp_if.redirect_pc, e.redir);
            check("branch_count", {16'b0, bp_if.branch_count}, {16'b0, e.branches});
            check("mispredict_count", {16'b0, bp_if.mispredict_count}, {16'b0, e.mispredicts});
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic checkPredict(input string tag, input logic [31:0] pc, input logic hit,
                                input logic taken, input logic [31:0] next_pc);
        bp_if.fetch_pc = pc;
        #1;
        check({tag, "_hit"}, {31'b0, bp_if.predict_hit}, {31'b0, hit});
        check({tag, "_taken"}, {31'b0, bp_if.predict_taken}, {31'b0, taken});
        check({tag, "_next"}, bp_if.predict_next_pc, next_pc);
    endtask

    task automatic resetModel();
        sb_q.delete();
        exp_redirect    = 32'h0;
        exp_branches    = 16'h0;
        exp_mispredicts = 16'h0;
    endtask

    initial begin
        resetModel();
        rst_n          = 1'b0;
        bp_if.fetch_pc = 32'h0;
        idle();
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        checkPredict("reset", 32'h00400010, 1'b0, 1'b0, 32'h00400014);
        check("reset_mispredict", {31'b0, bp_if.mispredict}, 32'h0);
        check("reset_redirect", bp_if.redirect_pc, 32'h0);
        check("reset_branch_count", {16'b0, bp_if.branch_count}, 32'h0);
        check("reset_mispredict_count", {16'b0, bp_if.mispredict_count}, 32'h0);

        // First taken resolution allocates the entry and mispredicts
        applyStimulus(1'b1, 32'h00400010, 1'b1, 32'h00400100, 1'b0, 32'h00400014);
        step();
        idle();
        step();
        checkPredict("alloc", 32'h00400010, 1'b1, 1'b1, 32'h00400100);
        check("counts_branch_1", {16'b0, bp_if.branch_count}, 32'd1);
        check("counts_mis_1", {16'b0, bp_if.mispredict_count}, 32'd1);

        // Two not-taken resolutions: 10 -> 01 (mispredict) -> 00 (correct, redirect held)
        applyStimulus(1'b1, 32'h00400010, 1'b0, 32'h00400100, 1'b1, 32'h00400100);
        step();
        checkPredict("ctr01", 32'h00400010, 1'b1, 1'b0, 32'h00400014);
        applyStimulus(1'b1, 32'h00400010, 1'b0, 32'h00400100, 1'b0, 32'h00400014);
        step();
        checkPredict("ctr00", 32'h00400010, 1'b1, 1'b0, 32'h00400014);

        // One taken from 00 only reaches 01, still predicting not taken
        applyStimulus(1'b1, 32'h00400010, 1'b1, 32'h00400100, 1'b0, 32'h00400014);
        step();
        checkPredict("ctr_floor", 32'h00400010, 1'b1, 1'b0, 32'h00400014);

        // Aliasing: same index, different tag replaces the entry
        applyStimulus(1'b1, 32'h00401010, 1'b1, 32'h00000040, 1'b0, 32'h00401014);
        step();
        checkPredict("alias_old", 32'h00400010, 1'b0, 1'b0, 32'h00400014);
        checkPredict("alias_new", 32'h00401010, 1'b1, 1'b1, 32'h00000040);

        // Same-cycle fetch and update of one index: old prediction now, new one next cycle
        applyStimulus(1'b1, 32'h00401010, 1'b0, 32'h00000040, 1'b1, 32'h00000040);
        checkPredict("same_cycle_pre", 32'h00401010, 1'b1, 1'b1, 32'h00000040);
        step();
        checkPredict("same_cycle_post", 32'h00401010, 1'b1, 1'b0, 32'h00401014);

        // Reset while a pulse is showing and an erroneous resolution is presented
        bp_if.resolve_valid        = 1'b1;
        bp_if.resolve_pc           = 32'h00400020;
        bp_if.resolve_taken        = 1'b1;
        bp_if.resolve_target       = 32'h00000200;
        bp_if.resolve_pred_taken   = 1'b0;
        bp_if.resolve_pred_next_pc = 32'h00400024;
        rst_n = 1'b0;
        resetModel();
        checkPredict("reset_mid", 32'h00401010, 1'b0, 1'b0, 32'h00401014);
        check("reset_mid_mispredict", {31'b0, bp_if.mispredict}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step();
        checkPredict("reset_after", 32'h00400020, 1'b0, 1'b0, 32'h00400024);

        // Drive both counters to all-ones with back-to-back mispredicting resolutions
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(1'b1, 32'h00400080, 1'b0, 32'h0, 1'b1, 32'h00400084);
            step();
        end
        check("sat_branch_full", {16'b0, bp_if.branch_count}, 32'h0000FFFF);
        check("sat_mis_full", {16'b0, bp_if.mispredict_count}, 32'h0000FFFF);
        applyStimulus(1'b1, 32'h00400080, 1'b0, 32'h0, 1'b1, 32'h00400084);
        step();
        check("sat_branch_hold", {16'b0, bp_if.branch_count}, 32'h0000FFFF);
        check("sat_mis_hold", {16'b0, bp_if.mispredict_count}, 32'h0000FFFF);
        idle();
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
